// File: rtl/rx_move_packer_pkg.sv
// Shared definitions for the move receive packer: FSM encodings, capture-flag position, default sizes.
package rx_move_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } rx_state_t;

    localparam int DEF_N_MOVES = 16;
    localparam int DEF_MOVE_W  = 10;
    localparam int DEF_FMT_W   = 16;
    localparam int DEF_PCS_W   = 10;
    localparam int DEF_N_PCS   = 8;
    localparam int DEF_COUNT_W = 16;

    // The capture flag always occupies the MSB of a formatted stack word.
    function automatic int capt_bit_pos(input int fmt_w);
        return fmt_w - 1;
    endfunction

endpackage

// File: rtl/rx_lane_pick.sv
// Combinational lowest-set-bit finder over a lane mask; any=0 when the mask is empty.
module rx_lane_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0]         mask,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downward so the lowest set lane is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ($clog2(N))'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_move_packer.sv
// Serialises batches of candidate moves onto the move stack and collects captured-piece tags.
// Optional build macro RX_STATS_EN adds the saturating mv_count statistics counter.
module rx_move_packer
    import rx_move_packer_pkg::*;
#(
    parameter int N_MOVES = DEF_N_MOVES,
    parameter int MOVE_W  = DEF_MOVE_W,
    parameter int FMT_W   = DEF_FMT_W,
    parameter int PCS_W   = DEF_PCS_W,
    parameter int N_PCS   = DEF_N_PCS
`ifdef RX_STATS_EN
    ,
    parameter int COUNT_W = DEF_COUNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_MOVES*MOVE_W-1:0] in_moves,
    input  logic [N_MOVES-1:0]       in_mask,
    input  logic [N_MOVES-1:0]       in_capt,
    output logic                     stk_valid,
    input  logic                     stk_ready,
    output logic [FMT_W-1:0]         stk_data,
    output logic                     batch_done,
    input  logic                     collect_pieces,
    input  logic [PCS_W-1:0]         dest_piece,
    input  logic                     pcs_clr,
    output logic [N_PCS*PCS_W-1:0]   rx_tx_pcs,
    output logic [N_PCS-1:0]         rx_tx_valid,
    output logic                     pcs_ovf
`ifdef RX_STATS_EN
    ,
    output logic [COUNT_W-1:0]       mv_count
`endif
);

    localparam int CAPT_BIT = capt_bit_pos(FMT_W);
    localparam int LANE_W   = $clog2(N_MOVES);
    localparam int PCNT_W   = $clog2(N_PCS + 1);

    function automatic logic [FMT_W-1:0] fmt_word(input logic [MOVE_W-1:0] mv, input logic capt);
        logic [FMT_W-1:0] w;
        w              = '0;
        w[MOVE_W-1:0]  = mv;
        w[CAPT_BIT]    = capt;
        return w;
    endfunction

    rx_state_t                 state, state_nxt;
    logic [N_MOVES-1:0]        pend_p1, pend_p0;
    logic [N_MOVES*MOVE_W-1:0] moves_p1, moves_p0;
    logic [N_MOVES-1:0]        capt_p1, capt_p0;
    logic [LANE_W-1:0]         lane_sel;
    logic                      lane_any;
    logic                      accept;
    logic                      stk_fire;

    assign accept   = (state == ST_IDLE) && in_valid && in_ready;
    assign stk_fire = (state == ST_DRAIN) && stk_valid && stk_ready;

    // Stage p0: next pending batch (load on accept, retire lowest lane on handshake)
    always_comb begin
        pend_p0  = pend_p1;
        moves_p0 = moves_p1;
        capt_p0  = capt_p1;
        if (accept) begin
            pend_p0  = in_mask;
            moves_p0 = in_moves;
            capt_p0  = in_capt;
        end else if (stk_fire) begin
            pend_p0 = pend_p1 & (pend_p1 - N_MOVES'(1));
        end
    end

    rx_lane_pick #(.N(N_MOVES)) u_pick (
        .mask (pend_p0),
        .idx  (lane_sel),
        .any  (lane_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = lane_any ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (!lane_any) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: registered control and outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pend_p1    <= '0;
            in_ready   <= 1'b1;
            stk_valid  <= 1'b0;
            batch_done <= 1'b0;
            stk_data   <= '0;
        end else begin
            state      <= state_nxt;
            pend_p1    <= pend_p0;
            in_ready   <= (state_nxt == ST_IDLE);
            stk_valid  <= (state_nxt == ST_DRAIN);
            batch_done <= (state_nxt == ST_DONE);
            if (state_nxt == ST_DRAIN)
                stk_data <= fmt_word(moves_p0[lane_sel*MOVE_W +: MOVE_W], capt_p0[lane_sel]);
        end
    end

    always_ff @(posedge clk) begin
        moves_p1 <= moves_p0;
        capt_p1  <= capt_p0;
    end

    logic [PCNT_W-1:0] pcs_cnt;

    // Slots fill contiguously from 0, so the occupancy popcount is also the next free slot.
    always_comb begin
        pcs_cnt = '0;
        for (int j = 0; j < N_PCS; j++)
            pcs_cnt = pcs_cnt + PCNT_W'(rx_tx_valid[j]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_tx_pcs   <= '0;
            rx_tx_valid <= '0;
            pcs_ovf     <= 1'b0;
        end else if (pcs_clr) begin
            rx_tx_valid <= collect_pieces ? N_PCS'(1) : '0;
            pcs_ovf     <= 1'b0;
            if (collect_pieces)
                rx_tx_pcs[0 +: PCS_W] <= dest_piece;
        end else if (collect_pieces) begin
            if (pcs_cnt < PCNT_W'(N_PCS)) begin
                for (int j = 0; j < N_PCS; j++) begin
                    if (PCNT_W'(j) == pcs_cnt) begin
                        rx_tx_pcs[j*PCS_W +: PCS_W] <= dest_piece;
                        rx_tx_valid[j]              <= 1'b1;
                    end
                end
            end else begin
                pcs_ovf <= 1'b1;
            end
        end
    end

`ifdef RX_STATS_EN
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            mv_count <= '0;
        else if (stk_fire)
            mv_count <= sat_inc(mv_count);
    end
`endif

endmodule

// File: tb/tb_rx_move_packer.sv
// Directed bench for rx_move_packer; with RX_STATS_EN it also checks mv_count saturation at COUNT_W=2.
module tb_rx_move_packer;

    localparam int N_MOVES = 16;
    localparam int MOVE_W  = 10;
    localparam int FMT_W   = 16;
    localparam int PCS_W   = 10;
    localparam int N_PCS   = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_MOVES*MOVE_W-1:0] in_moves;
    logic [N_MOVES-1:0]        in_mask;
    logic [N_MOVES-1:0]        in_capt;
    logic                      stk_valid;
    logic                      stk_ready;
    logic [FMT_W-1:0]          stk_data;
    logic                      batch_done;
    logic                      collect_pieces;
    logic [PCS_W-1:0]          dest_piece;
    logic                      pcs_clr;
    logic [N_PCS*PCS_W-1:0]    rx_tx_pcs;
    logic [N_PCS-1:0]          rx_tx_valid;
    logic                      pcs_ovf;
`ifdef RX_STATS_EN
    logic [1:0]                mv_count;
`endif

    always #5 clk = ~clk;

    rx_move_packer #(
        .N_MOVES (N_MOVES),
        .MOVE_W  (MOVE_W),
        .FMT_W   (FMT_W),
        .PCS_W   (PCS_W),
        .N_PCS   (N_PCS)
`ifdef RX_STATS_EN
        ,
        .COUNT_W (2)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_moves       (in_moves),
        .in_mask        (in_mask),
        .in_capt        (in_capt),
        .stk_valid      (stk_valid),
        .stk_ready      (stk_ready),
        .stk_data       (stk_data),
        .batch_done     (batch_done),
        .collect_pieces (collect_pieces),
        .dest_piece     (dest_piece),
        .pcs_clr        (pcs_clr),
        .rx_tx_pcs      (rx_tx_pcs),
        .rx_tx_valid    (rx_tx_valid),
        .pcs_ovf        (pcs_ovf)
`ifdef RX_STATS_EN
        ,
        .mv_count       (mv_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N_PCS*PCS_W-1:0] exp_pcs;

        rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_capt = '0; stk_ready = 1'b0;
        collect_pieces = 1'b0; dest_piece = '0; pcs_clr = 1'b0;
        for (int i = 0; i < N_MOVES; i++) in_moves[i*MOVE_W +: MOVE_W] = 10'h3C0 | 10'(i);

        tick; tick;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_stk_valid", stk_valid, 1'b0);
        check_eq("rst_stk_data", stk_data, 16'h0000);
        check_eq("rst_batch_done", batch_done, 1'b0);
        check_eq("rst_rx_tx_valid", rx_tx_valid, 8'h00);
        check_eq("rst_rx_tx_pcs", rx_tx_pcs, 80'h0);
        check_eq("rst_pcs_ovf", pcs_ovf, 1'b0);
`ifdef RX_STATS_EN
        check_eq("rst_mv_count", mv_count, 2'd0);
`endif
        rst = 1'b0;

        // Sparse mask, continuous ready
        in_mask = 16'h8421; in_capt = 16'h0020; in_valid = 1'b1; stk_ready = 1'b1;
        tick; in_valid = 1'b0;
        check_eq("b1_in_ready_busy", in_ready, 1'b0);
        check_eq("b1_valid0", stk_valid, 1'b1);
        check_eq("b1_lane0", stk_data, 16'h03C0);
        tick;
        check_eq("b1_lane5", stk_data, 16'h83C5);
`ifdef RX_STATS_EN
        check_eq("b1_mv1", mv_count, 2'd1);
`endif
        tick;
        check_eq("b1_lane10", stk_data, 16'h03CA);
        tick;
        check_eq("b1_lane15", stk_data, 16'h03CF);
        check_eq("b1_no_done_yet", batch_done, 1'b0);
`ifdef RX_STATS_EN
        check_eq("b1_mv3", mv_count, 2'd3);
`endif
        tick;
        check_eq("b1_valid_drop", stk_valid, 1'b0);
        check_eq("b1_done", batch_done, 1'b1);
        check_eq("b1_ready_in_done", in_ready, 1'b0);
`ifdef RX_STATS_EN
        check_eq("b1_mv_sat", mv_count, 2'd3);
`endif
        tick;
        check_eq("b1_done_pulse", batch_done, 1'b0);
        check_eq("b1_ready_back", in_ready, 1'b1);

        // Empty mask
        in_mask = 16'h0000; in_valid = 1'b1;
        tick; in_valid = 1'b0;
        check_eq("m0_no_valid", stk_valid, 1'b0);
        check_eq("m0_done", batch_done, 1'b1);
        check_eq("m0_ready_low", in_ready, 1'b0);
        tick;
        check_eq("m0_ready_back", in_ready, 1'b1);
        check_eq("m0_done_clear", batch_done, 1'b0);
        check_eq("m0_no_valid2", stk_valid, 1'b0);

        // Back-pressure hold
        in_mask = 16'h0003; in_capt = 16'h0000; stk_ready = 1'b0; in_valid = 1'b1;
        tick; in_valid = 1'b0;
        check_eq("bp_hold0", stk_data, 16'h03C0);
        for (int c = 1; c < 3; c++) begin
            tick;
            check_eq("bp_hold_valid", stk_valid, 1'b1);
            check_eq("bp_hold_data", stk_data, 16'h03C0);
        end
        stk_ready = 1'b1;
        tick;
        check_eq("bp_lane1", stk_data, 16'h03C1);
        check_eq("bp_lane1_valid", stk_valid, 1'b1);
        tick;
        check_eq("bp_done", batch_done, 1'b1);
        check_eq("bp_valid_drop", stk_valid, 1'b0);
        tick;
        check_eq("bp_ready_back", in_ready, 1'b1);

        // Piece buffer fill, overflow, clear-with-push
        for (int i = 1; i <= 9; i++) begin
            collect_pieces = 1'b1; dest_piece = 10'(i);
            tick;
            if (i == 3) check_eq("pcs_valid3", rx_tx_valid, 8'h07);
            if (i == 8) begin
                check_eq("pcs_valid8", rx_tx_valid, 8'hFF);
                check_eq("pcs_ovf8", pcs_ovf, 1'b0);
            end
        end
        collect_pieces = 1'b0;
        for (int j = 0; j < N_PCS; j++) exp_pcs[j*PCS_W +: PCS_W] = 10'(j + 1);
        check_eq("pcs_full_valid", rx_tx_valid, 8'hFF);
        check_eq("pcs_full_data", rx_tx_pcs, exp_pcs);
        check_eq("pcs_ovf_set", pcs_ovf, 1'b1);
        tick;
        check_eq("pcs_ovf_sticky", pcs_ovf, 1'b1);
        pcs_clr = 1'b1; collect_pieces = 1'b1; dest_piece = 10'd10;
        tick;
        pcs_clr = 1'b0; collect_pieces = 1'b0;
        check_eq("pcs_clr_valid", rx_tx_valid, 8'h01);
        check_eq("pcs_clr_slot0", rx_tx_pcs[0 +: PCS_W], 10'd10);
        check_eq("pcs_clr_slot1_kept", rx_tx_pcs[PCS_W +: PCS_W], 10'd2);
        check_eq("pcs_clr_ovf", pcs_ovf, 1'b0);

        // Reset in the middle of a full-mask drain
        in_mask = 16'hFFFF; in_capt = 16'h0000; in_valid = 1'b1; stk_ready = 1'b1;
        tick; in_valid = 1'b0;
        tick; tick;
        check_eq("rd_lane2", stk_data, 16'h03C2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("rd_in_ready", in_ready, 1'b1);
        check_eq("rd_stk_valid", stk_valid, 1'b0);
        check_eq("rd_batch_done", batch_done, 1'b0);
        check_eq("rd_stk_data", stk_data, 16'h0000);
`ifdef RX_STATS_EN
        check_eq("rd_mv_clear", mv_count, 2'd0);
`endif
        tick;
        check_eq("rd_no_done_later", batch_done, 1'b0);
        check_eq("rd_idle_valid", stk_valid, 1'b0);

        in_mask = 16'h0102; in_capt = 16'h0100; in_valid = 1'b1;
        tick; in_valid = 1'b0;
        check_eq("nb_lane1", stk_data, 16'h03C1);
        tick;
        check_eq("nb_lane8", stk_data, 16'h83C8);
        tick;
        check_eq("nb_done", batch_done, 1'b1);
        check_eq("nb_valid_drop", stk_valid, 1'b0);
`ifdef RX_STATS_EN
        check_eq("nb_mv2", mv_count, 2'd2);
`endif
        tick;
        check_eq("nb_ready_back", in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
